// File: rtl/boot_word_loader_pkg.sv
// rtl/boot_word_loader_pkg.sv - shared state encoding and header-field sizing for the boot word loader
package boot_word_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } loader_state_t;

    // The frame length must be able to express 2^ADDR_WIDTH words, so it needs one extra bit.
    function automatic int hdr_len_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/boot_word_loader_serial_bit_sync.sv
// rtl/boot_word_loader_serial_bit_sync.sv - synchronises ser_clk/ser_data and flags each ser_clk rising edge
module serial_bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ser_clk,
    input  logic ser_data,
    output logic bit_valid,
    output logic bit_value
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;

    // Both lines use equal-depth chains so the sampled data stays aligned with its strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
            bit_valid <= 1'b0;
            bit_value <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ser_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            bit_valid <= clk_sync[SYNC_STAGES-1] & ~clk_prev;
            bit_value <= data_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/boot_word_loader.sv
// rtl/boot_word_loader.sv - loads a length-prefixed, XOR-checked serial frame into a memory write port
module boot_word_loader
    import boot_word_loader_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  ser_clk,
    input  logic                  ser_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WORD_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam int HDR_W     = hdr_len_width(ADDR_WIDTH);
    localparam int BIT_CNT_W = $clog2(WORD_WIDTH);
    localparam int TMO_W     = $clog2(TIMEOUT + 1);

    loader_state_t          state;
    loader_state_t          state_next;
    logic                   bit_valid;
    logic                   bit_value;
    logic [WORD_WIDTH-1:0]  shift_reg;
    logic [WORD_WIDTH-1:0]  assembled;
    logic [WORD_WIDTH-1:0]  checksum;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [HDR_W-1:0]       frame_len;
    logic [HDR_W-1:0]       hdr_len;
    logic                   in_frame;
    logic                   word_done;
    logic                   timed_out;
    logic                   last_data;
    logic                   hdr_too_big;

    serial_bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .ser_clk  (ser_clk),
        .ser_data (ser_data),
        .bit_valid(bit_valid),
        .bit_value(bit_value)
    );

    assign in_frame    = (state == ST_HEADER) || (state == ST_DATA) || (state == ST_CHECK);
    assign assembled   = {shift_reg[WORD_WIDTH-2:0], bit_value};
    assign word_done   = in_frame && bit_valid && (bit_cnt == BIT_CNT_W'(WORD_WIDTH - 1));
    assign hdr_len     = assembled[HDR_W-1:0];
    assign hdr_too_big = hdr_len > {1'b1, {ADDR_WIDTH{1'b0}}};
    assign last_data   = (word_count + HDR_W'(1)) == frame_len;
    // An edge arriving on the expiry cycle wins, since bit_valid blocks the timeout.
    assign timed_out   = in_frame && !bit_valid && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    assign busy  = in_frame;
    assign done  = (state == ST_DONE);
    assign error = (state == ST_ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (enable && bit_valid) state_next = ST_HEADER;
            end
            ST_HEADER: begin
                if (word_done) begin
                    if (hdr_too_big)          state_next = ST_ERROR;
                    else if (hdr_len == '0)   state_next = ST_CHECK;
                    else                      state_next = ST_DATA;
                end else if (timed_out) begin
                    state_next = ST_ERROR;
                end
            end
            ST_DATA: begin
                if (word_done) begin
                    if (last_data) state_next = ST_CHECK;
                end else if (timed_out) begin
                    state_next = ST_ERROR;
                end
            end
            ST_CHECK: begin
                if (word_done)      state_next = (assembled == checksum) ? ST_DONE : ST_ERROR;
                else if (timed_out) state_next = ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (!enable) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (!enable) state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            checksum   <= '0;
            tmo_cnt    <= '0;
            frame_len  <= '0;
            word_count <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;

            if (bit_valid && (in_frame || (state == ST_IDLE && enable))) begin
                shift_reg <= assembled;
                bit_cnt   <= word_done ? '0 : bit_cnt + BIT_CNT_W'(1);
            end

            if (!in_frame || bit_valid) tmo_cnt <= '0;
            else                        tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (state == ST_IDLE && state_next == ST_HEADER) begin
                word_count <= '0;
                checksum   <= '0;
            end

            if (state == ST_HEADER && word_done) begin
                frame_len  <= hdr_len;
                word_count <= '0;
                checksum   <= '0;
            end

            if (state == ST_DATA && word_done && enable) begin
                wr_en      <= 1'b1;
                wr_addr    <= word_count[ADDR_WIDTH-1:0];
                wr_data    <= assembled;
                word_count <= word_count + HDR_W'(1);
                checksum   <= checksum ^ assembled;
            end

            // Leaving the frame drops any partially assembled word.
            if (!(state_next == ST_HEADER || state_next == ST_DATA || state_next == ST_CHECK)) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_boot_word_loader.sv
// tb/tb_boot_word_loader.sv - scoreboard bench for boot_word_loader
module tb_boot_word_loader;

    localparam int WW  = 32;
    localparam int AW  = 12;
    localparam int TMO = 300;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          ser_clk = 1'b0;
    logic          ser_data = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    int n_cmp = 0;
    int n_err = 0;
    wr_t exp_q[$];
    logic [WW-1:0] frame_q[$];

    boot_word_loader #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .SYNC_STAGES(2),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .ser_clk   (ser_clk),
        .ser_data  (ser_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write addr=%0h data=%0h required=no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    n_err++;
                    $display("FAIL write_payload addr=%0h data=%0h required addr=%0h data=%0h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog cycle budget expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_data = b;
        tick(2);
        ser_clk = 1'b1;
        tick(3);
        ser_clk = 1'b0;
        tick(1);
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        for (int i = WW - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Sends frame_q as data words, queueing each expected write, and returns the XOR checksum.
    task automatic send_data(output logic [WW-1:0] chk);
        chk = '0;
        for (int k = 0; k < frame_q.size(); k++) begin
            wr_t e;
            e.addr = AW'(k);
            e.data = frame_q[k];
            exp_q.push_back(e);
            chk ^= frame_q[k];
            send_word(frame_q[k]);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        n_cmp++; if (wr_en !== 1'b0)  begin n_err++; $display("FAIL reset_wr_en got=%0b want=0", wr_en); end
        n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%0b want=0", busy); end
        n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done got=%0b want=0", done); end
        n_cmp++; if (error !== 1'b0)  begin n_err++; $display("FAIL reset_error got=%0b want=0", error); end
        n_cmp++; if (wr_addr !== '0)  begin n_err++; $display("FAIL reset_wr_addr got=%0h want=0", wr_addr); end
        n_cmp++; if (wr_data !== '0)  begin n_err++; $display("FAIL reset_wr_data got=%0h want=0", wr_data); end
        n_cmp++; if (word_count !== '0) begin n_err++; $display("FAIL reset_word_count got=%0d want=0", word_count); end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_good_frame;
        logic [WW-1:0] chk;
        enable = 1'b1;
        tick(1);
        send_word(32'd3);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL good_busy got=%0b want=1", busy); end
        frame_q = '{32'h11111111, 32'h22222222, 32'h44444444};
        send_data(chk);
        n_cmp++; if (chk !== 32'h77777777) begin n_err++; $display("FAIL good_model_chk got=%0h want=77777777", chk); end
        send_word(chk);
        tick(8);
        n_cmp++; if (done !== 1'b1)  begin n_err++; $display("FAIL good_done got=%0b want=1", done); end
        n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL good_error got=%0b want=0", error); end
        n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL good_busy_end got=%0b want=0", busy); end
        n_cmp++; if (word_count !== 13'd3) begin n_err++; $display("FAIL good_word_count got=%0d want=3", word_count); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL good_missing_writes got=%0d want=0", exp_q.size()); end
        send_word(32'hFFFF0001);
        tick(8);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL good_done_hold got=%0b want=1", done); end
        enable = 1'b0;
        tick(2);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL good_idle_done got=%0b want=0", done); end
    endtask

    task automatic test_bad_checksum;
        logic [WW-1:0] chk;
        enable = 1'b1;
        tick(1);
        send_word(32'd2);
        frame_q = '{32'hA5A5A5A5, 32'h0F0F0F0F};
        send_data(chk);
        send_word(32'h00000000);
        tick(8);
        n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL badchk_error got=%0b want=1", error); end
        n_cmp++; if (done !== 1'b0)  begin n_err++; $display("FAIL badchk_done got=%0b want=0", done); end
        n_cmp++; if (word_count !== 13'd2) begin n_err++; $display("FAIL badchk_word_count got=%0d want=2", word_count); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL badchk_missing_writes got=%0d want=0", exp_q.size()); end
        enable = 1'b0;
        tick(2);
    endtask

    task automatic test_oversize;
        enable = 1'b1;
        tick(1);
        send_word(32'd4097);
        tick(8);
        n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL oversize_error got=%0b want=1", error); end
        send_word(32'h12345678);
        tick(8);
        n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL oversize_hold got=%0b want=1", error); end
        n_cmp++; if (word_count !== 13'd0) begin n_err++; $display("FAIL oversize_word_count got=%0d want=0", word_count); end
        enable = 1'b0;
        tick(2);
        n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL oversize_idle got=%0b want=0", error); end
    endtask

    task automatic test_empty_frame;
        enable = 1'b1;
        tick(1);
        send_word(32'd0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL empty_busy got=%0b want=1", busy); end
        send_word(32'd0);
        tick(8);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL empty_done got=%0b want=1", done); end
        n_cmp++; if (word_count !== 13'd0) begin n_err++; $display("FAIL empty_word_count got=%0d want=0", word_count); end
        enable = 1'b0;
        tick(2);
        n_cmp++; if ({busy, done, error} !== 3'b000) begin n_err++; $display("FAIL empty_idle got=%03b want=000", {busy, done, error}); end
    endtask

    task automatic test_timeout;
        logic [WW-1:0] chk;
        enable = 1'b1;
        tick(1);
        send_word(32'd3);
        frame_q = '{32'hCAFEF00D};
        send_data(chk);
        tick(TMO - 20);
        n_cmp++; if (busy !== 1'b1 || error !== 1'b0) begin n_err++; $display("FAIL tmo_short busy/error got=%0b/%0b want=1/0", busy, error); end
        for (int i = WW - 1; i >= WW - 10; i--) send_bit(1'b1);
        tick(TMO + 1);
        n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL tmo_error got=%0b want=1", error); end
        n_cmp++; if (word_count !== 13'd1) begin n_err++; $display("FAIL tmo_word_count got=%0d want=1", word_count); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL tmo_missing_writes got=%0d want=0", exp_q.size()); end
        enable = 1'b0;
        tick(2);
    endtask

    task automatic test_abort(input logic use_reset);
        logic [WW-1:0] chk;
        enable = 1'b1;
        tick(1);
        send_word(32'd4);
        frame_q = '{32'h01234567, 32'h89ABCDEF};
        send_data(chk);
        for (int i = WW - 1; i > WW - 20; i--) send_bit(1'b1);
        ser_data = 1'b0;
        tick(2);
        ser_clk = 1'b1;
        if (use_reset) reset = 1'b1;
        else           enable = 1'b0;
        tick(1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy rst=%0b got=%0b want=0", use_reset, busy); end
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL abort_wr_en rst=%0b got=%0b want=0", use_reset, wr_en); end
        ser_clk = 1'b0;
        tick(1);
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL abort_wr_en_next rst=%0b got=%0b want=0", use_reset, wr_en); end
        reset = 1'b0;
        tick(20);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL abort_missing_writes got=%0d want=0", exp_q.size()); end
        enable = 1'b1;
        tick(1);
        send_word(32'd1);
        frame_q = '{32'hDEADBEEF};
        send_data(chk);
        send_word(chk);
        tick(8);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL reload_done rst=%0b got=%0b want=1", use_reset, done); end
        n_cmp++; if (word_count !== 13'd1) begin n_err++; $display("FAIL reload_word_count got=%0d want=1", word_count); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL reload_missing_writes got=%0d want=0", exp_q.size()); end
        enable = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_oversize();
        test_empty_frame();
        test_timeout();
        test_abort(1'b0);
        test_abort(1'b1);
        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/boot_word_loader.md
BOOT_WORD_LOADER -- requirements
Module: boot_word_loader

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32, meaning the serial word length and write-data width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 12, meaning the target memory address width.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser depth on ser_clk and ser_data (minimum 2).
REQ-004 The block SHALL have parameter TIMEOUT, default 65535, meaning the maximum clk cycles allowed between ser_clk rising edges inside a frame.
REQ-005 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, meaning a synchronous, active-high reset.
REQ-007 The block SHALL have port enable, input, 1, meaning loading is permitted (CPU held in reset).
REQ-008 The block SHALL have port ser_clk, input, 1, meaning the asynchronous external bit strobe.
REQ-009 The block SHALL have port ser_data, input, 1, meaning the asynchronous external bit value.
REQ-010 The block SHALL have port wr_en, output, 1, meaning a one-cycle memory write strobe.
REQ-011 The block SHALL have port wr_addr, output, ADDR_WIDTH, meaning the write address.
REQ-012 The block SHALL have port wr_data, output, WORD_WIDTH, meaning the write data.
REQ-013 The block SHALL have ports busy, done and error, output, 1 each, meaning frame in progress, frame accepted and frame rejected.
REQ-014 The block SHALL have port word_count, output, ADDR_WIDTH+1, meaning the number of data words written in the current or last frame.

Function
REQ-015 The block SHALL pass ser_clk and ser_data through SYNC_STAGES flops and sample the synced ser_data on each synced ser_clk 0->1 transition, MSB first.
REQ-016 The block SHALL assemble a word when WORD_WIDTH bits have been sampled; the bit counter then wraps to 0.
REQ-017 The block SHALL implement states IDLE, HEADER, DATA, CHECK, DONE, ERROR.
REQ-018 From IDLE with enable=1 it SHALL go to HEADER on the first sampled bit; that bit is header bit MSB.
REQ-019 The header word's low ADDR_WIDTH+1 bits SHALL be N, the frame length; N > 2^ADDR_WIDTH SHALL go to ERROR; N=0 SHALL go to CHECK; otherwise it SHALL go to DATA.
REQ-020 In DATA, each completed word k (k=0..N-1) SHALL produce wr_en=1 for exactly one cycle, one clk after the last bit is sampled, with wr_addr=k and wr_data=word.
REQ-021 After each completed data word, word_count SHALL increment, and the running checksum SHALL be XORed with the word; after word N-1 the state SHALL go to CHECK.
REQ-022 In CHECK, a received word equal to the checksum SHALL go to DONE, otherwise ERROR; the checksum for N=0 is 0.
REQ-023 busy SHALL be 1 in HEADER, DATA and CHECK; done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR.
REQ-024 DONE and ERROR SHALL hold until enable falls, then go to IDLE; further ser_clk edges there SHALL be ignored.
REQ-025 In HEADER, DATA or CHECK, TIMEOUT cycles without a ser_clk edge SHALL go to ERROR, and the partial word SHALL be discarded.
REQ-026 enable falling in any state SHALL go to IDLE within one cycle with no further wr_en; already written words are not retracted.
REQ-027 In IDLE, or with enable=0, no wr_en SHALL ever be issued.
REQ-028 An edge coinciding with a timeout expiry SHALL count as the edge; the timeout counter SHALL clear on every edge.

Reset
REQ-029 When reset=1 at a clk edge, the block SHALL enter IDLE and clear the shift register, bit counter, checksum, timeout counter and synchroniser flops.
REQ-030 On reset, wr_en, busy, done and error SHALL be 0, and wr_addr, wr_data and word_count SHALL be 0.
REQ-031 Reset mid-frame SHALL abort the frame with no wr_en on that or the following cycle.

Structure
REQ-032 A shared package SHALL hold the state encoding and the header-field width constant (ADDR_WIDTH+1 derivation).
REQ-033 One sub-module, serial_bit_sync, SHALL perform synchronisation plus rising-edge detection and output bit_valid/bit_value.

Verification
REQ-034 The bench SHALL cover this: N=3, words 0x11111111, 0x22222222, 0x44444444, checksum 0x77777777 -> three wr_en pulses at addr 0,1,2, then done=1 and word_count=3.
REQ-035 The bench SHALL cover this: N=2, wrong checksum 0x00000000 -> two writes, then error=1 and done=0.
REQ-036 The bench SHALL cover this: header N=4097 with ADDR_WIDTH=12 -> error=1 and zero wr_en.
REQ-037 The bench SHALL cover this: N=0, checksum 0 -> done=1 with no writes; then enable low -> IDLE.
REQ-038 The bench SHALL cover this: ser_clk stalls for TIMEOUT+1 cycles mid-word 1 -> error=1 and only word 0 written.
REQ-039 The bench SHALL cover this: reset or enable low during the 20th bit of word 2 -> busy=0 next cycle, no further writes, then a new frame loads correctly.
